// File: rtl/keypad_scan.sv
// keypad_scan
// Matrix-keypad front end for a 4x3 keypad. It drives one column low at a
// time and samples the active-low rows through a 2-flop synchronizer. Each
// complete scan frame is classified as no key, one key, or several keys.
// The frame code is then debounced over DEB_FRAMES identical frames before
// it reaches the debounced outputs.
//
// Ports:
//   clk        1 kHz system clock
//   rst        asynchronous, active-low reset
//   key_row    keypad rows, active-low, pulled up, asynchronous to clk
//   key_col    column drive, active-low, one bit low outside reset
//   keypad     one-hot digit 0..9, held while the digit is stably pressed
//   key_star   '*' stably pressed
//   key_hash   '#' stably pressed
//   key_code   0..9 digit, 10 '*', 11 '#', 15 none
//   key_valid  one-cycle pulse on each new stable single-key press
module keypad_scan #(
  parameter int SETTLE     = 3,
  parameter int DEB_FRAMES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_row,
  output logic [2:0] key_col,
  output logic [9:0] keypad,
  output logic       key_star,
  output logic       key_hash,
  output logic [3:0] key_code,
  output logic       key_valid
);

  // A column must stay driven long enough for the synchronizer to deliver
  // its row levels before the sample point.
  if (SETTLE < 3) begin : g_settle_check
    $error("keypad_scan: SETTLE must be at least 3");
  end
  if (DEB_FRAMES < 1 || DEB_FRAMES > 15) begin : g_deb_check
    $error("keypad_scan: DEB_FRAMES must be in 1..15");
  end

  localparam int             SCW        = $clog2(SETTLE);
  localparam logic [SCW-1:0] SC_LAST    = SCW'(SETTLE - 1);
  localparam logic [3:0]     DEB_MAX    = 4'(DEB_FRAMES);
  localparam logic [3:0]     CODE_STAR  = 4'd10;
  localparam logic [3:0]     CODE_HASH  = 4'd11;
  localparam logic [3:0]     CODE_MULTI = 4'd14;
  localparam logic [3:0]     CODE_NONE  = 4'd15;

  logic [3:0]     row_meta;
  logic [3:0]     row_sync;
  logic [3:0]     row_s;
  logic [SCW-1:0] sc;
  logic [SCW-1:0] sc_next;
  logic [1:0]     col;
  logic [1:0]     col_next;
  logic           sample_pt;
  logic           frame_end;
  logic [3:0]     snap0;
  logic [3:0]     snap1;
  logic [11:0]    frame;
  logic [3:0]     n_keys;
  logic [3:0]     one_code;
  logic [3:0]     fc;
  logic [3:0]     cand;
  logic [3:0]     cnt;
  logic [3:0]     cand_next;
  logic [3:0]     cnt_next;

  // Frame bit index is col*4 + row. The result is the key code at that
  // matrix position.
  function automatic logic [3:0] key_at(input int idx);
    logic [3:0] code;
    case (idx)
      0:       code = 4'd1;
      1:       code = 4'd4;
      2:       code = 4'd7;
      3:       code = CODE_STAR;
      4:       code = 4'd2;
      5:       code = 4'd5;
      6:       code = 4'd8;
      7:       code = 4'd0;
      8:       code = 4'd3;
      9:       code = 4'd6;
      10:      code = 4'd9;
      default: code = CODE_HASH;
    endcase
    return code;
  endfunction

  // Two-flop synchronizer. Idle rows read high, so reset loads all ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= key_row;
      row_sync <= row_meta;
    end
  end

  assign row_s = ~row_sync;

  // Settle and column counters step continuously with no idle gap.
  always_comb begin
    sc_next  = sc + SCW'(1);
    col_next = col;
    if (sc == SC_LAST) begin
      sc_next  = '0;
      col_next = (col == 2'd2) ? 2'd0 : col + 2'd1;
    end
  end

  // key_col is registered from the next column value. This makes it track
  // col exactly, and it reads all-high only while reset is asserted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sc      <= '0;
      col     <= 2'd0;
      key_col <= 3'b111;
    end else begin
      sc      <= sc_next;
      col     <= col_next;
      key_col <= ~(3'b001 << col_next);
    end
  end

  assign sample_pt = (sc == SC_LAST);
  assign frame_end = sample_pt && (col == 2'd2);

  // Columns 0 and 1 are held in snapshots. Column 2 is used live at frame end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap0 <= 4'h0;
      snap1 <= 4'h0;
    end else if (sample_pt) begin
      if (col == 2'd0) snap0 <= row_s;
      if (col == 2'd1) snap1 <= row_s;
    end
  end

  assign frame = {row_s, snap1, snap0};

  // Classify the frame: no key, the single key's code, or multi-key.
  always_comb begin
    n_keys   = 4'd0;
    one_code = CODE_NONE;
    for (int i = 0; i < 12; i++) begin
      if (frame[i]) begin
        n_keys   = n_keys + 4'd1;
        one_code = key_at(i);
      end
    end
    if (n_keys == 4'd0)      fc = CODE_NONE;
    else if (n_keys == 4'd1) fc = one_code;
    else                     fc = CODE_MULTI;
  end

  // Debounce. A run of identical frames counts up and saturates. Any
  // different frame restarts the run at 1.
  always_comb begin
    cand_next = cand;
    cnt_next  = cnt;
    if (fc == cand) begin
      if (cnt != DEB_MAX) cnt_next = cnt + 4'd1;
    end else begin
      cand_next = fc;
      cnt_next  = 4'd1;
    end
  end

  // Outputs change only when a run reaches full length on a new code.
  // Multi-key is reported like a release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cand      <= CODE_NONE;
      cnt       <= 4'd0;
      keypad    <= 10'd0;
      key_star  <= 1'b0;
      key_hash  <= 1'b0;
      key_code  <= CODE_NONE;
      key_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (frame_end) begin
        cand <= cand_next;
        cnt  <= cnt_next;
        if (cnt_next == DEB_MAX && cand_next != key_code) begin
          keypad   <= 10'd0;
          key_star <= 1'b0;
          key_hash <= 1'b0;
          if (cand_next <= 4'd9) begin
            keypad    <= 10'd1 << cand_next;
            key_code  <= cand_next;
            key_valid <= 1'b1;
          end else if (cand_next == CODE_STAR) begin
            key_star  <= 1'b1;
            key_code  <= CODE_STAR;
            key_valid <= 1'b1;
          end else if (cand_next == CODE_HASH) begin
            key_hash  <= 1'b1;
            key_code  <= CODE_HASH;
            key_valid <= 1'b1;
          end else begin
            key_code <= CODE_NONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan
// Bench for keypad_scan. A behavioural keypad matrix drives the rows from
// the set of held keys. A frame-level reference model predicts every output
// on every cycle. Key changes are applied only right after frame ends, so
// each scan frame sees exactly one key set.
module tb_keypad_scan;

  localparam int S     = 3;
  localparam int DEB   = 3;
  localparam int FRAME = 3 * S;

  logic       clk;
  logic       rst;
  logic [3:0] key_row;
  logic [2:0] key_col;
  logic [9:0] keypad;
  logic       key_star;
  logic       key_hash;
  logic [3:0] key_code;
  logic       key_valid;

  // pressed[k] = key with code k is held (10 = '*', 11 = '#')
  logic [11:0] pressed;

  int checks;
  int failures;
  int n;
  int pulses;

  int         m_cand;
  int         m_cnt;
  logic [9:0] exp_keypad;
  logic       exp_star;
  logic       exp_hash;
  int         exp_code;
  logic       exp_valid;

  keypad_scan #(.SETTLE(S), .DEB_FRAMES(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_row   (key_row),
    .key_col   (key_col),
    .keypad    (keypad),
    .key_star  (key_star),
    .key_hash  (key_hash),
    .key_code  (key_code),
    .key_valid (key_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int row_of(input int k);
    if (k >= 1 && k <= 9) return (k - 1) / 3;
    return 3;
  endfunction

  function automatic int col_of(input int k);
    if (k >= 1 && k <= 9) return (k - 1) % 3;
    if (k == 0) return 1;
    if (k == 10) return 0;
    return 2;
  endfunction

  // Passive matrix. A row is pulled low through any held key whose column
  // is currently driven low.
  always_comb begin
    key_row = 4'hF;
    for (int k = 0; k < 12; k++) begin
      if (pressed[k] && key_col[2'(col_of(k))] == 1'b0)
        key_row[2'(row_of(k))] = 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_cand     = 15;
    m_cnt      = 0;
    exp_keypad = 10'd0;
    exp_star   = 1'b0;
    exp_hash   = 1'b0;
    exp_code   = 15;
    exp_valid  = 1'b0;
  endtask

  // One scan frame at the specification level. During the first frame after
  // reset, column 0 is driven only from the first edge. Its rows have not yet
  // crossed the synchronizer at its sample point, so column-0 keys stay unseen.
  task automatic model_frame_end();
    logic [11:0] seen;
    int nk;
    int fc;
    seen = pressed;
    if (n == FRAME) begin
      for (int k = 0; k < 12; k++)
        if (col_of(k) == 0) seen[k] = 1'b0;
    end
    nk = $countones(seen);
    fc = 15;
    if (nk > 1) fc = 14;
    else if (nk == 1) begin
      for (int k = 0; k < 12; k++)
        if (seen[k]) fc = k;
    end
    if (fc == m_cand) begin
      if (m_cnt < DEB) m_cnt++;
    end else begin
      m_cand = fc;
      m_cnt  = 1;
    end
    if (m_cnt == DEB && m_cand != exp_code) begin
      exp_keypad = 10'd0;
      exp_star   = 1'b0;
      exp_hash   = 1'b0;
      if (m_cand <= 9) begin
        exp_keypad[m_cand] = 1'b1;
        exp_code  = m_cand;
        exp_valid = 1'b1;
      end else if (m_cand == 10) begin
        exp_star  = 1'b1;
        exp_code  = 10;
        exp_valid = 1'b1;
      end else if (m_cand == 11) begin
        exp_hash  = 1'b1;
        exp_code  = 11;
        exp_valid = 1'b1;
      end else begin
        exp_code = 15;
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_col"},   16'(key_col),   16'h7);
    checkOutput({tag, "_pad"},   16'(keypad),    16'h0);
    checkOutput({tag, "_star"},  16'(key_star),  16'h0);
    checkOutput({tag, "_hash"},  16'(key_hash),  16'h0);
    checkOutput({tag, "_code"},  16'(key_code),  16'hF);
    checkOutput({tag, "_valid"}, 16'(key_valid), 16'h0);
  endtask

  // Advance cycles. The model steps after each rising edge, and all outputs
  // are compared on the falling edge.
  task automatic run_cycles(input int count);
    logic [2:0] exp_col;
    for (int c = 0; c < count; c++) begin
      @(posedge clk);
      n++;
      exp_valid = 1'b0;
      if (n % FRAME == 0) model_frame_end();
      exp_col = 3'b111;
      exp_col[2'((n / S) % 3)] = 1'b0;
      @(negedge clk);
      if (key_valid) pulses++;
      checkOutput("key_col",   16'(key_col),   16'(exp_col));
      checkOutput("keypad",    16'(keypad),    16'(exp_keypad));
      checkOutput("key_star",  16'(key_star),  16'(exp_star));
      checkOutput("key_hash",  16'(key_hash),  16'(exp_hash));
      checkOutput("key_code",  16'(key_code),  16'(exp_code));
      checkOutput("key_valid", 16'(key_valid), 16'(exp_valid));
    end
  endtask

  task automatic applyStimulus(input logic [11:0] keys, input int frames);
    pressed = keys;
    run_cycles(frames * FRAME);
  endtask

  initial begin
    logic [11:0] keys;
    int kind;
    int a;
    int b;
    checks   = 0;
    failures = 0;
    pulses   = 0;
    n        = 0;
    pressed  = 12'd0;
    rst      = 1'b0;
    model_reset();

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b1;

    // Idle scan
    applyStimulus(12'h000, 22);
    checkOutput("idle_pulses", 16'(pulses), 16'd0);

    // Press 5, then release
    pulses = 0;
    applyStimulus(12'h020, 11);
    applyStimulus(12'h000, 5);
    checkOutput("press5_pulses", 16'(pulses), 16'd1);

    // '#' with one bounced frame
    pulses = 0;
    applyStimulus(12'h800, 1);
    applyStimulus(12'h000, 1);
    applyStimulus(12'h800, 6);
    applyStimulus(12'h000, 4);
    checkOutput("hash_pulses", 16'(pulses), 16'd1);

    // Hold 1, add 9, release 1
    pulses = 0;
    applyStimulus(12'h002, 5);
    applyStimulus(12'h202, 5);
    applyStimulus(12'h200, 5);
    applyStimulus(12'h000, 4);
    checkOutput("multi_pulses", 16'(pulses), 16'd2);

    // Roll from 3 to 0 with no release
    pulses = 0;
    applyStimulus(12'h008, 5);
    applyStimulus(12'h001, 5);
    applyStimulus(12'h000, 4);
    checkOutput("roll_pulses", 16'(pulses), 16'd2);

    // Reset while 7 is stable, then hold 7 through the release
    applyStimulus(12'h080, 5);
    run_cycles(4);
    rst = 1'b0;
    #1;
    check_reset_values("async_rst");
    repeat (3) begin
      @(negedge clk);
      check_reset_values("held_rst");
    end
    rst = 1'b1;
    n = 0;
    model_reset();
    pulses = 0;
    applyStimulus(12'h080, 6);
    checkOutput("rerep7_pulses", 16'(pulses), 16'd1);
    applyStimulus(12'h000, 4);

    // Random key sets held for random frame counts
    for (int seg = 0; seg < 40; seg++) begin
      kind = $urandom_range(0, 9);
      if (kind < 2) begin
        keys = 12'd0;
      end else if (kind < 8) begin
        keys = 12'd1 << $urandom_range(0, 11);
      end else begin
        a = $urandom_range(0, 11);
        b = (a + $urandom_range(1, 11)) % 12;
        keys = (12'd1 << a) | (12'd1 << b);
      end
      applyStimulus(keys, $urandom_range(1, 5));
    end
    applyStimulus(12'h000, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
